cpu_bus_sequencer: RTL
======================

CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

Interface
REQ-001 SHALL have parameter PH_DIV, default 2, meaning clk cycles per bus quarter-phase (legal 1..15).
REQ-002 SHALL have port clk  in  1  master clock; all state on its rising edge.
REQ-003 SHALL have port rst  in  1  reset. Reset is asynchronous and active-high.
REQ-004 SHALL have port cpu_as_n  in  1  CPU address strobe, active low.
REQ-005 SHALL have port cpu_rnw  in  1  CPU read(1)/write(0).
REQ-006 SHALL have port cpu_addr  in  16  CPU address.
REQ-007 SHALL have ports woco, init, rmrd  in  1 each  bank-select controls.
REQ-008 SHALL have port vid_pal_req  in  1  video palette fetch request, level.
REQ-009 SHALL have port vid_pal_addr  in  10  video palette address.
REQ-010 SHALL have ports cpu_e, cpu_q  out  1 each  CPU quadrature clocks.
REQ-011 SHALL have ports cs_io_n, cs_cram_n, cs_vram_n, cs_obj_n  out  1 each  chip selects, active low.
REQ-012 SHALL have port we_n  out  1  write strobe, active low.
REQ-013 SHALL have port vid_pal_gnt  out  1  palette RAM granted to video this phase.
REQ-014 SHALL have port cram_addr  out  10  palette RAM address mux output.

Function
REQ-015 Phase tick SHALL fire once every PH_DIV clk cycles; all state advances only on a tick.
REQ-016 FSM states: P0 (E=0,Q=0), P1 (E=0,Q=1), STR (E=0,Q=1), P2 (E=1,Q=1), P3 (E=1,Q=0).
REQ-017 Transitions: P0->P1; P1->STR if stretch condition, else P1->P2; STR->P2; P2->P3; P3->P0.
REQ-018 On P0->P1, cpu_as_n, cpu_rnw, cpu_addr, woco, init and rmrd SHALL be latched; decode SHALL use only the latched values until the next P0->P1.
REQ-019 Decode (latched AS low only): CRAM = 0000-03FF & woco=1.
REQ-020 Decode: IO = 5F80-5F9F.
REQ-021 Decode: OBJ = rmrd=0 & init=1 & (7800-7807 | 7C00-7FFF).
REQ-022 Decode: VRAM = 4000-7FFF minus IO minus OBJ.
REQ-023 Decode: at most one region SHALL be active; all others SHALL select nothing.
REQ-024 Selected cs_*_n SHALL be low in P1, STR, P2 and P3 of that cycle and high in P0.
REQ-025 Chip selects SHALL be registered outputs.
REQ-026 we_n SHALL be low in P2 and P3 only when latched cpu_rnw=0 and a region is selected; otherwise high.
REQ-027 Stretch condition: latched region is CRAM and vid_pal_req=1 at the P1 tick; at most one STR per bus cycle.
REQ-028 vid_pal_gnt SHALL be 1 in STR.
REQ-029 vid_pal_gnt SHALL be 1 in P0 when vid_pal_req=1.
REQ-030 vid_pal_gnt SHALL be 0 in all other states.
REQ-031 cram_addr SHALL equal vid_pal_addr when vid_pal_gnt=1, else latched cpu_addr[9:0].
REQ-032 When cs_cram_n is low and the state is not STR, the CPU SHALL own the palette RAM; video SHALL never be granted in P1, P2 or P3.
REQ-033 A vid_pal_req deasserted mid-phase SHALL NOT truncate a grant already issued for that phase.
REQ-034 Latched AS high at P0->P1 SHALL produce an idle cycle with no selects, no we_n and no stretch.

Reset
REQ-035 rst=1 SHALL immediately force state P0 and clear the divider counter.
REQ-036 rst=1 SHALL force cpu_e=0, cpu_q=0, all cs_*_n=1, we_n=1, vid_pal_gnt=0, cram_addr=0 and clear the latches.
REQ-037 Release of rst SHALL start at P0, with the first tick PH_DIV clk cycles later.
REQ-038 Reset asserted mid-cycle (including in STR) SHALL abort the cycle with no partial we_n pulse after assertion.

Verification
REQ-039 Scenario: PH_DIV=2, AS low, addr 5F85, read -> cs_io_n low for 6 clks (P1-P3); we_n stays high; E/Q period 8 clks.
REQ-040 Scenario: addr 0123, woco=1, write, vid_pal_req=0 -> cs_cram_n low; we_n low in P2-P3; cram_addr=0x123; no STR.
REQ-041 Scenario: same as REQ-040 with vid_pal_req=1, vid_pal_addr=0x2AA -> STR inserted (E low/Q high one extra phase); vid_pal_gnt=1 and cram_addr=0x2AA in STR; then CPU address; cycle length 10 clks.
REQ-042 Scenario: addr 7C10, rmrd=0, init=1 -> cs_obj_n low. Same with rmrd=1 -> cs_vram_n low.
REQ-043 Scenario: addr 7805 vs 7808 with init=1, rmrd=0 -> OBJ vs VRAM. Addr 0123 with woco=0 -> no select.
REQ-044 Scenario: rst pulsed during P2 of a write -> we_n high and all selects high within the same clk; restart from P0.

Source files
------------

// File: rtl/cpu_bus_sequencer.sv
// CPU bus sequencer: quadrature E/Q phase generator, latched address decode,
// registered chip selects/write strobe and palette RAM arbitration with video.
module cpu_bus_sequencer #(
  parameter int unsigned PH_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_as_n,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_addr,
  input  logic        woco,
  input  logic        init,
  input  logic        rmrd,
  input  logic        vid_pal_req,
  input  logic [9:0]  vid_pal_addr,
  output logic        cpu_e,
  output logic        cpu_q,
  output logic        cs_io_n,
  output logic        cs_cram_n,
  output logic        cs_vram_n,
  output logic        cs_obj_n,
  output logic        we_n,
  output logic        vid_pal_gnt,
  output logic [9:0]  cram_addr
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(PH_DIV - 1);

  typedef enum logic [2:0] {P0, P1, STR, P2, P3} state_t;
  typedef enum logic [2:0] {R_NONE, R_IO, R_CRAM, R_VRAM, R_OBJ} region_t;

  // Region decode; priority order keeps the regions mutually exclusive.
  function automatic region_t decode(input logic        as_n,
                                     input logic [15:0] a,
                                     input logic        wc,
                                     input logic        in,
                                     input logic        rm);
    logic is_cram, is_io, is_obj, is_vram;
    is_cram = (a[15:10] == 6'h00) && wc;
    is_io   = (a >= 16'h5F80) && (a <= 16'h5F9F);
    is_obj  = !rm && in && (((a >= 16'h7800) && (a <= 16'h7807)) ||
                            ((a >= 16'h7C00) && (a <= 16'h7FFF)));
    is_vram = (a >= 16'h4000) && (a <= 16'h7FFF);
    if (as_n)         return R_NONE;
    else if (is_cram) return R_CRAM;
    else if (is_io)   return R_IO;
    else if (is_obj)  return R_OBJ;
    else if (is_vram) return R_VRAM;
    else              return R_NONE;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  region_t          region_q, region_d;
  logic             rnw_q, rnw_d;
  logic [9:0]       addr_lo_q, addr_lo_d;
  logic             cpu_e_q, cpu_e_d;
  logic             cpu_q_q, cpu_q_d;
  logic             cs_io_n_q, cs_io_n_d;
  logic             cs_cram_n_q, cs_cram_n_d;
  logic             cs_vram_n_q, cs_vram_n_d;
  logic             cs_obj_n_q, cs_obj_n_d;
  logic             we_n_q, we_n_d;
  logic             gnt_q, gnt_d;
  logic [9:0]       cram_addr_q, cram_addr_d;
  logic             tick_c;
  logic             active_c;

  assign tick_c = (cnt_q == TICK_AT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      state_q     <= P0;
      region_q    <= R_NONE;
      rnw_q       <= 1'b0;
      addr_lo_q   <= '0;
      cpu_e_q     <= 1'b0;
      cpu_q_q     <= 1'b0;
      cs_io_n_q   <= 1'b1;
      cs_cram_n_q <= 1'b1;
      cs_vram_n_q <= 1'b1;
      cs_obj_n_q  <= 1'b1;
      we_n_q      <= 1'b1;
      gnt_q       <= 1'b0;
      cram_addr_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      region_q    <= region_d;
      rnw_q       <= rnw_d;
      addr_lo_q   <= addr_lo_d;
      cpu_e_q     <= cpu_e_d;
      cpu_q_q     <= cpu_q_d;
      cs_io_n_q   <= cs_io_n_d;
      cs_cram_n_q <= cs_cram_n_d;
      cs_vram_n_q <= cs_vram_n_d;
      cs_obj_n_q  <= cs_obj_n_d;
      we_n_q      <= we_n_d;
      gnt_q       <= gnt_d;
      cram_addr_q <= cram_addr_d;
    end
  end

  // Next state and next registered outputs; everything moves only on a tick.
  always_comb begin
    cnt_d       = tick_c ? '0 : cnt_q + CNT_W'(1);
    state_d     = state_q;
    region_d    = region_q;
    rnw_d       = rnw_q;
    addr_lo_d   = addr_lo_q;
    cpu_e_d     = cpu_e_q;
    cpu_q_d     = cpu_q_q;
    cs_io_n_d   = cs_io_n_q;
    cs_cram_n_d = cs_cram_n_q;
    cs_vram_n_d = cs_vram_n_q;
    cs_obj_n_d  = cs_obj_n_q;
    we_n_d      = we_n_q;
    gnt_d       = gnt_q;
    cram_addr_d = cram_addr_q;
    active_c    = 1'b0;

    if (tick_c) begin
      unique case (state_q)
        P0: begin
          state_d   = P1;
          rnw_d     = cpu_rnw;
          addr_lo_d = cpu_addr[9:0];
          region_d  = decode(cpu_as_n, cpu_addr, woco, init, rmrd);
        end
        P1:      state_d = ((region_q == R_CRAM) && vid_pal_req) ? STR : P2;
        STR:     state_d = P2;
        P2:      state_d = P3;
        P3:      state_d = P0;
        default: state_d = P0;
      endcase

      active_c    = (state_d != P0);
      cpu_e_d     = (state_d == P2) || (state_d == P3);
      cpu_q_d     = (state_d == P1) || (state_d == STR) || (state_d == P2);
      cs_io_n_d   = !(active_c && (region_d == R_IO));
      cs_cram_n_d = !(active_c && (region_d == R_CRAM));
      cs_vram_n_d = !(active_c && (region_d == R_VRAM));
      cs_obj_n_d  = !(active_c && (region_d == R_OBJ));
      we_n_d      = !(cpu_e_d && !rnw_d && (region_d != R_NONE));
      // Grant is sampled once per phase so a request dropped mid-phase keeps it.
      gnt_d       = (state_d == STR) || ((state_d == P0) && vid_pal_req);
      cram_addr_d = gnt_d ? vid_pal_addr : addr_lo_d;
    end
  end

  assign cpu_e       = cpu_e_q;
  assign cpu_q       = cpu_q_q;
  assign cs_io_n     = cs_io_n_q;
  assign cs_cram_n   = cs_cram_n_q;
  assign cs_vram_n   = cs_vram_n_q;
  assign cs_obj_n    = cs_obj_n_q;
  assign we_n        = we_n_q;
  assign vid_pal_gnt = gnt_q;
  assign cram_addr   = cram_addr_q;

endmodule
